// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of a combinational 2-bit-opcode ALU, with a registered
// result stage (data, opcode, zero, carry) on a valid/ready output port.
module alu_cmd_queue #(
   parameter int ALU_WIDTH = 16,
   parameter int DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_opcode,
   input  logic [ALU_WIDTH-1:0]      cmd_a,
   input  logic [ALU_WIDTH-1:0]      cmd_b,
   output logic [ALU_WIDTH-1:0]      alu_a,
   output logic [ALU_WIDTH-1:0]      alu_b,
   output logic [1:0]                alu_opcode,
   input  logic [ALU_WIDTH-1:0]      alu_result,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [ALU_WIDTH-1:0]      res_data,
   output logic [1:0]                res_opcode,
   output logic                      res_zero,
   output logic                      res_carry,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [ALU_WIDTH-1:0] mem_a  [DEPTH];
   logic [ALU_WIDTH-1:0] mem_b  [DEPTH];
   logic [1:0]           mem_op [DEPTH];

   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic                 empty;
   logic                 push;
   logic                 fire;
   logic [ALU_WIDTH:0]   sum_ext;
   logic                 carry_next;

   assign empty     = (level == '0);
   assign cmd_ready = (level != FULL_LVL);
   assign push      = cmd_valid && cmd_ready;
   assign fire      = !empty && (!res_valid || res_ready);

   // Head is read from storage only, so cmd_* never reaches the ALU combinationally.
   assign alu_a      = empty ? '0 : mem_a[rd_ptr];
   assign alu_b      = empty ? '0 : mem_b[rd_ptr];
   assign alu_opcode = empty ? '0 : mem_op[rd_ptr];

   assign sum_ext = {1'b0, alu_a} + {1'b0, alu_b};

   always_comb begin
      carry_next = 1'b0;
      case (alu_opcode)
         2'b00:   carry_next = sum_ext[ALU_WIDTH];
         2'b01:   carry_next = (alu_a < alu_b);
         default: carry_next = 1'b0;
      endcase
   end

   // Payload storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]  <= cmd_a;
         mem_b[wr_ptr]  <= cmd_b;
         mem_op[wr_ptr] <= cmd_opcode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_opcode <= '0;
         res_zero   <= 1'b0;
         res_carry  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (fire) rd_ptr <= rd_ptr + 1'b1;

         case ({push, fire})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase

         if (fire) begin
            res_valid  <= 1'b1;
            res_data   <= alu_result;
            res_opcode <= alu_opcode;
            res_zero   <= (alu_result == '0);
            res_carry  <= carry_next;
         end else if (res_valid && res_ready) begin
            res_valid  <= 1'b0;
         end
      end
   end

endmodule
